// File: rtl/instruction_stack_pkg.sv
// Shared constants for the CPU return-address stack.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: default pointer/data widths and the PC increment applied on a call.
package instruction_stack_pkg;

  // Default stack pointer width; depth is 2**ADDR_WIDTH entries.
  localparam int ADDR_WIDTH = 4;
  // Default PC / return-address width.
  localparam int DATA_WIDTH = 16;
  // Return address is the instruction after the call.
  localparam int PC_INC     = 1;

endpackage : instruction_stack_pkg

// File: rtl/instruction_stack_mem.sv
// Register array holding return addresses; synchronous write, asynchronous read.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none, a write is accepted on every edge with we=1.
// Ports:
//   clk   - clock, write on rising edge
//   we    - write enable
//   waddr - write slot
//   wdata - value written
//   raddr - read slot
//   rdata - combinational read of mem[raddr]
module instruction_stack_mem #(
  parameter int addr_width = 4,
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  localparam int DEPTH = 1 << addr_width;

  // Contents are intentionally not reset; count in the parent guards reads.
  logic [data_width-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : instruction_stack_mem

// File: rtl/instruction_stack.sv
// Hardware return-address stack: call pushes PC+1, rtrn pops into a registered output.
// Latency: push poppable the next edge; popped value on o_Stack right after the rtrn edge.
// Backpressure: none; overflow overwrites the oldest entry, rtrn on empty is ignored.
// Ports:
//   clk     - clock, all state updates on rising edge
//   rst     - synchronous active-high reset (priority over call/rtrn)
//   i_PC    - PC of the instruction issuing the call
//   call    - push request (wins over rtrn when both asserted)
//   rtrn    - pop request
//   o_Stack - return address from the most recent successful pop
module instruction_stack
  import instruction_stack_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH,
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] i_PC,
  input  logic                  call,
  input  logic                  rtrn,
  output logic [data_width-1:0] o_Stack
);

  // count value meaning "all slots valid"; also the saturation point.
  localparam logic [addr_width:0] FULL = {1'b1, {addr_width{1'b0}}};

  logic [addr_width-1:0] sp_q, sp_d;
  logic [addr_width:0]   count_q, count_d;
  logic [data_width-1:0] o_stack_q, o_stack_d;

  logic                  push;
  logic                  pop;
  logic                  mem_we;
  logic [addr_width-1:0] rd_addr;
  logic [data_width-1:0] rd_data;
  logic [data_width-1:0] ret_addr;

  // Wraps naturally at data_width bits, so a call at the top PC stores 0.
  assign ret_addr = i_PC + data_width'(PC_INC);
  // sp points at the next free slot, so the top of stack is one below it.
  assign rd_addr  = sp_q - addr_width'(1);
  assign mem_we   = push && !rst;

  always_comb begin
    sp_d      = sp_q;
    count_d   = count_q;
    o_stack_d = o_stack_q;
    push      = call;
    // call has priority; a pop needs at least one valid entry.
    pop       = rtrn && !call && (count_q != '0);

    if (push) begin
      // sp keeps wrapping on overflow so the oldest entry is overwritten.
      sp_d = sp_q + addr_width'(1);
      if (count_q != FULL) begin
        count_d = count_q + (addr_width + 1)'(1);
      end
    end else if (pop) begin
      sp_d      = sp_q - addr_width'(1);
      count_d   = count_q - (addr_width + 1)'(1);
      o_stack_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q      <= '0;
      count_q   <= '0;
      o_stack_q <= '0;
    end else begin
      sp_q      <= sp_d;
      count_q   <= count_d;
      o_stack_q <= o_stack_d;
    end
  end

  assign o_Stack = o_stack_q;

  instruction_stack_mem #(
    .addr_width(addr_width),
    .data_width(data_width)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(sp_q),
    .wdata(ret_addr),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule : instruction_stack

// File: tb/tb_instruction_stack.sv
// Self-checking bench for instruction_stack: directed plan followed by random traffic,
// compared against a queue-based model of a bounded LIFO that drops its oldest entry.
module tb_instruction_stack;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [15:0] i_PC;
  logic        call;
  logic        rtrn;
  logic [15:0] o_Stack;

  int n_checks;
  int n_fails;

  // Reference model: newest entry at the back of the queue.
  logic [15:0] model_q[$];
  logic [15:0] exp_out;

  instruction_stack dut (
    .clk    (clk),
    .rst    (rst),
    .i_PC   (i_PC),
    .call   (call),
    .rtrn   (rtrn),
    .o_Stack(o_Stack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    n_checks++;
    assert (o_Stack === exp_out)
    else begin
      n_fails++;
      $error("FAIL %s: o_Stack observed %h expected %h", tag, o_Stack, exp_out);
    end
  endtask

  // Apply the model's view of one rising edge.
  task automatic model_edge(input logic c, input logic r, input logic [15:0] pc,
                            input logic rs);
    logic [15:0] ra;
    if (rs) begin
      model_q.delete();
      exp_out = 16'h0000;
    end else if (c) begin
      ra = pc + 16'd1;
      if (model_q.size() == DEPTH) void'(model_q.pop_front());
      model_q.push_back(ra);
    end else if (r && model_q.size() > 0) begin
      exp_out = model_q.pop_back();
    end
  endtask

  task automatic step(input logic c, input logic r, input logic [15:0] pc,
                      input logic rs, input string tag);
    @(negedge clk);
    call = c;
    rtrn = r;
    i_PC = pc;
    rst  = rs;
    @(posedge clk);
    model_edge(c, r, pc, rs);
    #1;
    check(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_out  = 16'h0000;
    rst  = 1'b0;
    call = 1'b0;
    rtrn = 1'b0;
    i_PC = 16'h0000;

    // Reset, then a pop on empty must leave the output at 0.
    step(1'b0, 1'b0, 16'h0, 1'b1, "reset");
    step(1'b0, 1'b1, 16'h0, 1'b0, "rtrn_empty_after_reset");

    // Single call / return.
    step(1'b1, 1'b0, 16'd10, 1'b0, "call_10");
    step(1'b0, 1'b1, 16'd0, 1'b0, "ret_11");

    // Nested calls, 0x10..0x90, then unwind.
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 16'(i * 16), 1'b0, "nested_call");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h0, 1'b0, "nested_ret");
    step(1'b0, 1'b1, 16'h0, 1'b0, "nested_ret_empty");

    // Overflow: 17 pushes, 16 pops (17..2), then an extra pop on empty.
    for (int i = 0; i <= 16; i++) step(1'b1, 1'b0, 16'(i), 1'b0, "ovf_call");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0, 1'b0, "ovf_ret");
    step(1'b0, 1'b1, 16'h0, 1'b0, "ovf_ret_empty");

    // Simultaneous call+rtrn: push of wrapped 0, output held; next pop yields 0.
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, "simul_call_rtrn");
    step(1'b0, 1'b1, 16'h0, 1'b0, "ret_wrapped_zero");

    // Reset mid-operation discards pending entries.
    step(1'b0, 1'b1, 16'h0, 1'b0, "pre_reset_empty");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(100 + i), 1'b0, "mid_call");
    step(1'b0, 1'b1, 16'h0, 1'b0, "mid_ret");
    step(1'b0, 1'b0, 16'h0, 1'b1, "mid_reset");
    step(1'b0, 1'b1, 16'h0, 1'b0, "ret_after_reset");

    // A reset glitch between edges must not disturb the stack.
    step(1'b1, 1'b0, 16'd5, 1'b0, "glitch_call");
    @(negedge clk);
    call = 1'b0;
    rtrn = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 1'b0, 16'h0, 1'b0);
    #1;
    check("glitch_idle");
    step(1'b0, 1'b1, 16'h0, 1'b0, "ret_after_glitch");

    // Random traffic, biased so the stack both fills and drains.
    for (int i = 0; i < 600; i++) begin
      logic c, r, rs;
      int phase;
      phase = (i / 60) % 2;
      c  = ($urandom_range(0, 99) < (phase == 0 ? 65 : 30));
      r  = ($urandom_range(0, 99) < 55);
      rs = ($urandom_range(0, 99) < 2);
      step(c, r, 16'($urandom), rs, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_instruction_stack

// File: doc/instruction_stack.md
# instruction_stack

Hardware return-address stack for the CPU sequencer. On a subroutine call it pushes the return address (current PC + 1). On a return it pops that address onto a registered output, which the program counter logic loads as the next PC. It sits between the instruction decoder (call/rtrn strobes) and the PC register.

## Interface
- `addr_width`, default 4: stack pointer width; depth = 2^addr_width entries (16).
- `data_width`, default 16: PC / return-address width.

Ports, in the order clock, reset, then signals:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `i_PC`  in  data_width: PC of the instruction issuing the call.
- `call`  in  1: push request, sampled on the rising edge.
- `rtrn`  in  1: pop request, sampled on the rising edge.
- `o_Stack`  out  data_width: registered return address from the last pop.

## Operation
- State:
  - `sp`: addr_width bits, points to the next free slot.
  - `count`: addr_width+1 bits, 0..2^addr_width.
  - `mem`: 2^addr_width × data_width.
  - `o_Stack` register.
- Reset (rst=1 at an edge): sp=0, count=0, o_Stack=0. `mem` contents are not cleared. Reset has priority over call and rtrn.
- Call (call=1, rst=0):
  - mem[sp] ← (i_PC + 1) mod 2^data_width, so i_PC=16'hFFFF stores 0.
  - sp ← sp+1 (wraps).
  - count ← min(count+1, 2^addr_width).
  - o_Stack unchanged.
- Return (rtrn=1, call=0, rst=0, count>0):
  - o_Stack ← mem[sp-1].
  - sp ← sp-1.
  - count ← count-1.
- Return on empty (count=0): no state change; o_Stack holds its value.
- Overflow: a call with count = 2^addr_width still writes. Because sp wraps, the oldest entry is overwritten (circular). count stays saturated. After 2^addr_width pops the stack reports empty.
- Simultaneous call and rtrn: the call has priority and the rtrn is ignored that cycle.
- Idle (neither asserted): all state holds.

## Timing
- Push latency 1 cycle: an entry written at edge N is poppable at edge N+1. Back-to-back call then rtrn on consecutive edges returns the just-pushed value.
- Pop latency: o_Stack shows the popped value immediately after the rtrn edge and holds it until the next successful pop or reset.
- Consecutive rtrn cycles pop one entry per edge.
- A reset pulse that does not span a rising edge has no effect.

## Structure
- Shared package `instruction_stack_pkg`: default `ADDR_WIDTH=4` and `DATA_WIDTH=16` constants, plus the PC increment constant (1).
- One sub-module, `instruction_stack_mem`: a parameterized synchronous-write, asynchronous-read register array. The pointer, count and output register live in the top level.

## Test plan
- Reset: hold rst=1 across one edge → o_Stack=0, count=0. A following rtrn leaves o_Stack=0.
- Single call/return:
  - i_PC=10, call=1 for one edge.
  - Then i_PC=0, rtrn=1 for one edge → o_Stack=11.
- Nested calls:
  - call on 9 consecutive edges with i_PC=16'h10,16'h20,…,16'h90.
  - Then rtrn on consecutive edges → o_Stack = 16'h91, 16'h81, …, 16'h21, 16'h11.
- Overflow:
  - 17 calls with i_PC=0..16.
  - 16 returns → o_Stack = 17, 16, …, 2; the first entry (1) has been overwritten.
  - A 17th rtrn leaves o_Stack=2.
- Simultaneous and wrap:
  - call=rtrn=1 with i_PC=16'hFFFF → push of 0, o_Stack unchanged.
  - Next rtrn → o_Stack=0.
- Reset mid-operation: 3 calls, then reset, then rtrn → o_Stack=0 (empty, no pop).
